// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs format, register fields and a signed immediate
// into an instruction word through a 2-stage valid/ready pipeline.
module inst_encoder #(
    parameter int unsigned COUNT_W  = 16,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         fmt_in,
    input  logic [2:0]         funct3_in,
    input  logic               arith_in,
    input  logic [4:0]         rd_in,
    input  logic [4:0]         rs1_in,
    input  logic [4:0]         rs2_in,
    input  logic [31:0]        imm_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        inst_out,
    output logic               out_err,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);

    localparam int unsigned INST_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned IMM_W  = 21;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        FMT_IALU   = 3'd0,
        FMT_ISHIFT = 3'd1,
        FMT_LOAD   = 3'd2,
        FMT_S      = 3'd3,
        FMT_B      = 3'd4,
        FMT_JAL    = 3'd5,
        FMT_JALR   = 3'd6,
        FMT_ILL    = 3'd7
    } fmt_e;

    // Only imm[20:0] is needed once the range check is done in stage 1.
    typedef struct packed {
        fmt_e              fmt;
        logic [F3_W-1:0]   funct3;
        logic              arith;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [IMM_W-1:0]  imm;
        logic              err;
    } req_t;

    req_t              s1_d;
    req_t              s1_q;
    logic              s1_valid;
    logic              s2_free;
    logic              s1_advance;
    logic              accept;
    logic              xfer;
    logic              fit12_c;
    logic              fit13_c;
    logic              fit21_c;
    logic [INST_W-1:0] asm_c;

    // Handshake: a stage moves when the one after it is empty or draining.
    assign s2_free    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_free;
    assign in_ready   = rst_n && (!s1_valid || s1_advance);
    assign accept     = in_valid && in_ready;
    assign xfer       = out_valid && out_ready;

    // Sign-extension checks: the upper bits must all equal the field sign bit.
    assign fit12_c = (&imm_in[31:11]) || !(|imm_in[31:11]);
    assign fit13_c = (&imm_in[31:12]) || !(|imm_in[31:12]);
    assign fit21_c = (&imm_in[31:20]) || !(|imm_in[31:20]);

    // Stage 1 next value: capture fields and decide encodability.
    always_comb begin
        s1_d        = '0;
        s1_d.fmt    = fmt_e'(fmt_in);
        s1_d.funct3 = funct3_in;
        s1_d.arith  = arith_in;
        s1_d.rd     = rd_in;
        s1_d.rs1    = rs1_in;
        s1_d.rs2    = rs2_in;
        s1_d.imm    = imm_in[IMM_W-1:0];
        case (fmt_e'(fmt_in))
            FMT_IALU, FMT_LOAD, FMT_S: s1_d.err = !fit12_c;
            FMT_JALR: begin
                s1_d.err    = !fit12_c;
                s1_d.funct3 = 3'b000;
            end
            FMT_ISHIFT: s1_d.err = (|imm_in[31:5]) ||
                                   !((funct3_in == 3'b001) || (funct3_in == 3'b101));
            FMT_B:      s1_d.err = !fit13_c || imm_in[0];
            FMT_JAL:    s1_d.err = !fit21_c || imm_in[0];
            FMT_ILL:    s1_d.err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_q     <= s1_d;
            end else if (s1_advance) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Stage 2 word assembly; an unencodable request becomes the NOP word.
    always_comb begin
        asm_c = NOP_INST;
        case (s1_q.fmt)
            FMT_IALU:   asm_c = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, OP_IMM};
            FMT_ISHIFT: asm_c = {1'b0, s1_q.arith, 5'b00000, s1_q.imm[4:0], s1_q.rs1,
                                 s1_q.funct3, s1_q.rd, OP_IMM};
            FMT_LOAD:   asm_c = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, OP_LOAD};
            FMT_JALR:   asm_c = {s1_q.imm[11:0], s1_q.rs1, s1_q.funct3, s1_q.rd, OP_JALR};
            FMT_S:      asm_c = {s1_q.imm[11:5], s1_q.rs2, s1_q.rs1, s1_q.funct3,
                                 s1_q.imm[4:0], OP_STORE};
            FMT_B:      asm_c = {s1_q.imm[12], s1_q.imm[10:5], s1_q.rs2, s1_q.rs1,
                                 s1_q.funct3, s1_q.imm[4:1], s1_q.imm[11], OP_BRANCH};
            FMT_JAL:    asm_c = {s1_q.imm[20], s1_q.imm[10:1], s1_q.imm[11],
                                 s1_q.imm[19:12], s1_q.rd, OP_JAL};
            FMT_ILL:    asm_c = NOP_INST;
        endcase
        if (s1_q.err) begin
            asm_c = NOP_INST;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            inst_out  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (s1_advance) begin
                out_valid <= 1'b1;
                inst_out  <= asm_c;
                out_err   <= s1_q.err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating transfer statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count <= '0;
            err_count <= '0;
        end else if (xfer) begin
            if (enc_count != '1) begin
                enc_count <= enc_count + COUNT_W'(1);
            end
            if (out_err && (err_count != '1)) begin
                err_count <= err_count + COUNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed bench for inst_encoder: reference encoder model, ordered scoreboard,
// immediate round-trip decode and saturating counter model.
module tb_inst_encoder;

    localparam int unsigned CW     = 4;
    localparam int unsigned CMAX   = 15;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    fmt_in = '0;
    logic [2:0]    funct3_in = '0;
    logic          arith_in = 1'b0;
    logic [4:0]    rd_in = '0;
    logic [4:0]    rs1_in = '0;
    logic [4:0]    rs2_in = '0;
    logic [31:0]   imm_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [31:0]   inst_out;
    logic          out_err;
    logic [CW-1:0] enc_count;
    logic [CW-1:0] err_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_count = 0;
    int exp_enc = 0;
    int exp_err = 0;
    bit hold_prev = 1'b0;

    typedef struct {
        int          fmt;
        int          imm;
        logic [31:0] w;
        logic        e;
        int          acc;
    } exp_t;
    exp_t q[$];

    inst_encoder #(.COUNT_W(CW), .NOP_INST(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .fmt_in(fmt_in), .funct3_in(funct3_in), .arith_in(arith_in),
        .rd_in(rd_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .imm_in(imm_in),
        .out_valid(out_valid), .out_ready(out_ready), .inst_out(inst_out),
        .out_err(out_err), .enc_count(enc_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int lo, input int n);
        return (v >> lo) & ((32'd1 << n) - 32'd1);
    endfunction

    // Reference encoder: legality from numeric ranges, word from field positions.
    function automatic void model(input int fmt, input int f3, input int arith, input int rd,
                                  input int rs1, input int rs2, input int imm,
                                  output logic [31:0] w, output logic e);
        logic [31:0] u, r_d, r_s1, r_s2, f;
        u = imm; r_d = rd; r_s1 = rs1 << 15; r_s2 = rs2 << 20; r_d = r_d << 7;
        f = (fmt == 6) ? 32'd0 : 32'(f3) << 12;
        w = NOP;
        e = 1'b0;
        case (fmt)
            0, 2, 6: begin
                e = (imm < -2048) || (imm > 2047);
                w = (fld(u, 0, 12) << 20) | r_s1 | f | r_d |
                    ((fmt == 0) ? 32'h13 : (fmt == 2) ? 32'h03 : 32'h67);
            end
            1: begin
                e = (imm < 0) || (imm > 31) || !((f3 == 1) || (f3 == 5));
                w = (32'(arith) << 30) | (fld(u, 0, 5) << 20) | r_s1 | f | r_d | 32'h13;
            end
            3: begin
                e = (imm < -2048) || (imm > 2047);
                w = (fld(u, 5, 7) << 25) | r_s2 | r_s1 | f | (fld(u, 0, 5) << 7) | 32'h23;
            end
            4: begin
                e = (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
                w = (fld(u, 12, 1) << 31) | (fld(u, 5, 6) << 25) | r_s2 | r_s1 | f |
                    (fld(u, 1, 4) << 8) | (fld(u, 11, 1) << 7) | 32'h63;
            end
            5: begin
                e = (imm < -(1 << 20)) || (imm > (1 << 20) - 2) || ((imm & 1) != 0);
                w = (fld(u, 20, 1) << 31) | (fld(u, 1, 10) << 21) | (fld(u, 11, 1) << 20) |
                    (fld(u, 12, 8) << 12) | r_d | 32'h6F;
            end
            default: e = 1'b1;
        endcase
        if (e) w = NOP;
    endfunction

    // Immediate as a decoder would recover it from an emitted word.
    function automatic int decode(input int fmt, input logic [31:0] w);
        logic signed [11:0] i12;
        logic signed [12:0] b13;
        logic signed [20:0] j21;
        case (fmt)
            1: return int'(w[24:20]);
            3: begin i12 = {w[31:25], w[11:7]}; return int'(i12); end
            4: begin b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0}; return int'(b13); end
            5: begin j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0}; return int'(j21); end
            default: begin i12 = w[31:20]; return int'(i12); end
        endcase
    endfunction

    // Compare process: one sample per cycle, away from the rising edge.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] w;
        logic        er;
        #1;
        cyc++;
        if (rst_n) begin
            check("enc_count", 32'(enc_count), 32'(exp_enc));
            check("err_count", 32'(err_count), 32'(exp_err));
            if (hold_prev) check("out_valid_held", 32'(out_valid), 32'd1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_out_valid: got word %h with no pending request", inst_out);
                end else begin
                    e = q[0];
                    check("inst_out", inst_out, e.w);
                    check("out_err", 32'(out_err), 32'(e.e));
                    if (cyc - e.acc < 2) begin
                        checks++; errors++;
                        $display("FAIL latency: got %0d cycles required >= 2", cyc - e.acc);
                    end
                    if (!out_err) check("round_trip_imm", 32'(decode(e.fmt, inst_out)), 32'(e.imm));
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (exp_enc < CMAX) exp_enc++;
                        if (e.e && exp_err < CMAX) exp_err++;
                    end
                end
            end
            hold_prev = out_valid && !out_ready;
            if (in_valid && in_ready) begin
                model(int'(fmt_in), int'(funct3_in), int'(arith_in), int'(rd_in),
                      int'(rs1_in), int'(rs2_in), int'($signed(imm_in)), w, er);
                e.fmt = int'(fmt_in); e.imm = int'($signed(imm_in));
                e.w = w; e.e = er; e.acc = cyc;
                q.push_back(e);
                acc_count++;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    // Present one request from a falling edge; return on the falling edge after accept.
    task automatic send(input int fmt, input int f3, input int arith, input int rd,
                        input int rs1, input int rs2, input int imm);
        in_valid = 1'b1;
        fmt_in = 3'(fmt); funct3_in = 3'(f3); arith_in = 1'(arith);
        rd_in = 5'(rd); rs1_in = 5'(rs1); rs2_in = 5'(rs2); imm_in = 32'(imm);
        for (int i = 0; i < 100; i++) begin
            #2;
            if (in_ready) begin
                @(negedge clk);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++; errors++;
        $display("FAIL send_timeout: got in_ready=0 for 100 cycles required accept");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        #2;
        while (q.size() != 0 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d words pending required 0", q.size());
        end
        @(negedge clk);
    endtask

    task automatic pin(input string name, input int fmt, input int f3, input int arith,
                       input int rd, input int rs1, input int rs2, input int imm,
                       input logic [31:0] ew, input logic ee);
        logic [31:0] w;
        logic        e;
        model(fmt, f3, arith, rd, rs1, rs2, imm, w, e);
        check({name, "_word"}, w, ew);
        check({name, "_err"}, 32'(e), 32'(ee));
    endtask

    initial begin
        int base;
        // Model pinned against hand-encoded words.
        pin("m_addi", 0, 0, 0, 1, 2, 0, -1, 32'hFFF10093, 1'b0);
        pin("m_srai", 1, 5, 1, 5, 5, 0, 3, 32'h4032D293, 1'b0);
        pin("m_jal", 5, 0, 0, 1, 0, 0, 8, 32'h008000EF, 1'b0);
        pin("m_beq", 4, 0, 0, 0, 1, 2, -4, 32'hFE208EE3, 1'b0);
        pin("m_beq_odd", 4, 0, 0, 0, 1, 2, 3, NOP, 1'b1);
        pin("m_jalr", 6, 3, 0, 1, 2, 0, -2048, 32'h800100E7, 1'b0);

        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_inst_out", inst_out, 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_enc_count", 32'(enc_count), 32'd0);
        #12 rst_n = 1'b1;
        @(negedge clk);

        // Back-pressure: two held in the pipe, then in_ready drops.
        base = acc_count;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(0, 0, 0, i + 1, i + 2, 0, i * 10);
            end
            begin
                #3;
                @(negedge clk);
                @(negedge clk);
                #3;
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_accepted", 32'(acc_count - base), 32'd2);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();
        #2 check("burst_enc_count", 32'(enc_count), 32'd4);
        @(negedge clk);

        // First word latency: empty, one cycle in stage 1, then valid.
        send(0, 0, 0, 1, 2, 0, -1);
        #2 check("lat_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        #2 check("lat_cycle2_valid", 32'(out_valid), 32'd1);
        check("lat_addi_word", inst_out, 32'hFFF10093);
        @(negedge clk);
        drain();

        send(1, 5, 1, 5, 5, 0, 3);
        drain();
        send(5, 0, 0, 1, 0, 0, 8);
        drain();
        send(4, 0, 0, 0, 1, 2, -4);
        drain();
        send(4, 0, 0, 0, 1, 2, 3);
        drain();
        #2 check("err_count_after_b_odd", 32'(err_count), 32'd1);
        @(negedge clk);
        send(0, 0, 0, 3, 4, 0, 2048);
        send(1, 1, 0, 3, 4, 0, 32);
        send(0, 0, 0, 3, 4, 0, 2047);
        send(6, 3, 0, 1, 2, 0, -2048);
        send(4, 1, 0, 0, 7, 8, 4094);
        send(5, 0, 0, 31, 0, 0, -(1 << 20));
        drain();

        // Counter saturation with mixed legal and illegal requests.
        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) send(7, 0, 0, i, i, i, 0);
            else if (i % 3 == 1) send(3, 2, 0, 0, i, i + 1, i * 100 - 500);
            else send(2, 2, 0, i, i + 1, 0, i * 100 - 500);
        end
        drain();
        #2 check("sat_enc_count", 32'(enc_count), 32'd15);
        check("sat_err_count", 32'(err_count), 32'd7);
        @(negedge clk);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        send(0, 0, 0, 9, 9, 0, 5);
        send(2, 0, 0, 9, 9, 0, 6);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_enc_count", 32'(enc_count), 32'd0);
        check("mid_rst_err_count", 32'(err_count), 32'd0);
        q.delete();
        exp_enc = 0;
        exp_err = 0;
        @(negedge clk);
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2 check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_enc_count", 32'(enc_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
